// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT frame decoder: FSM states, frame byte
// offsets, range-limit defaults and small arithmetic helpers.
package dht_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FRAME_W     = 40;
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TEM_INT_LSB = 16;
  localparam int TEM_DEC_LSB = 8;
  localparam int CSUM_LSB    = 0;

  localparam int HUM_MAX_DEF = 99;
  localparam int TEM_MAX_DEF = 50;

  localparam int NUM_CONV  = 2;
  localparam int BCD_STEPS = 8;

  // Low byte of the four data bytes; the 8-bit result width does the mod 256.
  function automatic logic [7:0] dht_csum(input logic [FRAME_W-1:0] f);
    return f[HUM_INT_LSB +: 8] + f[HUM_DEC_LSB +: 8] +
           f[TEM_INT_LSB +: 8] + f[TEM_DEC_LSB +: 8];
  endfunction

  function automatic logic [7:0] bcd_add3(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
    if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit binary to two BCD digits, 8 cycles
// from start (first bit absorbed in the start cycle), done pulses once.
module bin2bcd_seq
  import dht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o,
  output logic       done_o
);

  logic [7:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  // Only tens/units are kept: lower digits never depend on the hundreds digit.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      bcd_d = {7'd0, bin_i[7]};
      bin_d = {bin_i[6:0], 1'b0};
      cnt_d = 4'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 4'(BCD_STEPS)) begin
        run_d = 1'b0;
      end else begin
        bcd_d = 8'({bcd_add3(bcd_q), bin_q[7]});
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = run_q && (cnt_q == 4'(BCD_STEPS));

endmodule

// File: rtl/dht_frame_decode.sv
// DHT frame decoder: checksum and range check, then parallel BCD conversion of
// humidity/temperature integers. Define DHT_ERRCNT_EN for a saturating error counter.
module dht_frame_decode
  import dht_pkg::*;
#(
  parameter int HUM_MAX = HUM_MAX_DEF,
  parameter int TEM_MAX = TEM_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_valid_i,
  output logic [7:0]         hum_bcd_o,
  output logic [7:0]         tem_bcd_o,
  output logic               data_valid_o,
  output logic               csum_err_o,
  output logic               range_err_o,
  output logic               busy_o,
  output logic [7:0]         err_cnt_o
);

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [7:0]         hum_bcd_q, tem_bcd_q;
  logic               dv_q, cerr_q, rerr_q;

  logic [7:0] hum_int, tem_int;
  logic       csum_ok, range_ok, conv_start, conv_all_done;

  logic [NUM_CONV-1:0][7:0] conv_in;
  logic [NUM_CONV-1:0][7:0] conv_bcd;
  logic [NUM_CONV-1:0]      conv_done;

  assign hum_int  = frame_q[HUM_INT_LSB +: 8];
  assign tem_int  = frame_q[TEM_INT_LSB +: 8];
  assign csum_ok  = (dht_csum(frame_q) == frame_q[CSUM_LSB +: 8]);
  assign range_ok = (int'(hum_int) <= HUM_MAX) && (int'(tem_int) <= TEM_MAX);

  assign conv_start    = (state_q == CHECK) && csum_ok && range_ok;
  assign conv_in[0]    = hum_int;
  assign conv_in[1]    = tem_int;
  assign conv_all_done = &conv_done;

  for (genvar g = 0; g < NUM_CONV; g++) begin : g_conv
    bin2bcd_seq u_bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (conv_start),
      .bin_i   (conv_in[g]),
      .bcd_o   (conv_bcd[g]),
      .done_o  (conv_done[g])
    );
  end

  // Frames arriving outside IDLE are dropped silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      hum_bcd_q <= '0;
      tem_bcd_q <= '0;
      dv_q      <= 1'b0;
      cerr_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      cerr_q <= 1'b0;
      rerr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_valid_i) begin
            frame_q <= frame_i;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!csum_ok) begin
            cerr_q  <= 1'b1;
            state_q <= IDLE;
          end else if (!range_ok) begin
            rerr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= CONV;
          end
        end
        CONV: begin
          if (conv_all_done) begin
            hum_bcd_q <= conv_bcd[0];
            tem_bcd_q <= conv_bcd[1];
            dv_q      <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hum_bcd_o    = hum_bcd_q;
  assign tem_bcd_o    = tem_bcd_q;
  assign data_valid_o = dv_q;
  assign csum_err_o   = cerr_q;
  assign range_err_o  = rerr_q;
  assign busy_o       = (state_q != IDLE);

`ifdef DHT_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((cerr_q || rerr_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dht_frame_decode.sv
// Randomized bench for dht_frame_decode against an event-level model of the
// frame protocol, plus directed frames with hand-computed expectations.
module tb_dht_frame_decode;

  localparam int HUM_MAX = 99;
  localparam int TEM_MAX = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] frame_i = '0;
  logic        frame_valid_i = 1'b0;
  logic [7:0]  hum_bcd_o, tem_bcd_o, err_cnt_o;
  logic        data_valid_o, csum_err_o, range_err_o, busy_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dht_frame_decode #(.HUM_MAX(HUM_MAX), .TEM_MAX(TEM_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .hum_bcd_o     (hum_bcd_o),
    .tem_bcd_o     (tem_bcd_o),
    .data_valid_o  (data_valid_o),
    .csum_err_o    (csum_err_o),
    .range_err_o   (range_err_o),
    .busy_o        (busy_o),
    .err_cnt_o     (err_cnt_o)
  );

  // ---------------- reference model (event level) ----------------
  int k = 0;
  int busy_last = -1;
  int m_pend = 0, m_at = 0, m_kind = 0, m_h = 0, m_t = 0;
  int e_hum = 0, e_tem = 0, e_dv = 0, e_ce = 0, e_re = 0, e_busy = 0, e_cnt = 0;

  function automatic int to_bcd(input int v);
    return ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic logic [39:0] mk(input int hi, input int hd, input int ti,
                                     input int td, input int cs_xor);
    int s;
    s = ((hi + hd + ti + td) % 256) ^ cs_xor;
    return {8'(hi), 8'(hd), 8'(ti), 8'(td), 8'(s)};
  endfunction

  initial begin : model
    int hi, hd, ti, td, cs;
    forever begin
      @(posedge clk);
      k++;
      if (rst) begin
        m_pend = 0; busy_last = -1;
        e_hum = 0; e_tem = 0; e_dv = 0; e_ce = 0; e_re = 0; e_cnt = 0;
      end else begin
`ifdef DHT_ERRCNT_EN
        if ((e_ce != 0 || e_re != 0) && e_cnt < 255) e_cnt++;
`endif
        e_dv = 0; e_ce = 0; e_re = 0;
        if (m_pend != 0 && m_at == k) begin
          m_pend = 0;
          if (m_kind == 0) begin e_dv = 1; e_hum = m_h; e_tem = m_t; end
          else if (m_kind == 1) e_ce = 1;
          else e_re = 1;
        end
        // accepted only if busy was low during the cycle before this edge
        if (frame_valid_i && (k - 1 > busy_last)) begin
          hi = frame_i[39:32]; hd = frame_i[31:24];
          ti = frame_i[23:16]; td = frame_i[15:8]; cs = frame_i[7:0];
          m_pend = 1;
          if ((hi + hd + ti + td) % 256 != cs) begin
            m_kind = 1; m_at = k + 1; busy_last = k;
          end else if (hi > HUM_MAX || ti > TEM_MAX) begin
            m_kind = 2; m_at = k + 1; busy_last = k;
          end else begin
            m_kind = 0; m_at = k + 9; busy_last = k + 9;
            m_h = to_bcd(hi); m_t = to_bcd(ti);
          end
        end
      end
      e_busy = (k <= busy_last) ? 1 : 0;
    end
  end

  // ---------------- checking / stimulus ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("cyc hum_bcd", int'(hum_bcd_o), e_hum);
      check("cyc tem_bcd", int'(tem_bcd_o), e_tem);
      check("cyc data_valid", int'(data_valid_o), e_dv);
      check("cyc csum_err", int'(csum_err_o), e_ce);
      check("cyc range_err", int'(range_err_o), e_re);
      check("cyc busy", int'(busy_o), e_busy);
      check("cyc err_cnt", int'(err_cnt_o), e_cnt);
    end
  endtask

  task automatic pulse(input logic [39:0] f);
    frame_i = f;
    frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
    frame_i = {8'($urandom), 32'($urandom)};
  endtask

  int w_dv_at, w_dv_n, w_ce_at, w_ce_n, w_re_at, w_re_n;

  // Cycle numbers count from the sampling edge: first cycle after it is 1.
  task automatic watch(input int n);
    w_dv_at = -1; w_dv_n = 0; w_ce_at = -1; w_ce_n = 0; w_re_at = -1; w_re_n = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (data_valid_o) begin w_dv_n++; if (w_dv_at < 0) w_dv_at = i + 1; end
      if (csum_err_o)   begin w_ce_n++; if (w_ce_at < 0) w_ce_at = i + 1; end
      if (range_err_o)  begin w_re_n++; if (w_re_at < 0) w_re_at = i + 1; end
    end
  endtask

  initial begin : stim
    int kind, hi, ti;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset hum", int'(hum_bcd_o), 0);
    check("reset tem", int'(tem_bcd_o), 0);
    check("reset dv", int'(data_valid_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset cnt", int'(err_cnt_o), 0);
    rst = 1'b0;
    tick();

    pulse(40'h37_00_18_00_4F);
    watch(14);
    check("good dv cycle", w_dv_at, 10);
    check("good dv count", w_dv_n, 1);
    check("good hum", int'(hum_bcd_o), 'h55);
    check("good tem", int'(tem_bcd_o), 'h24);

    pulse(40'h37_00_18_00_50);
    watch(14);
    check("csum cycle", w_ce_at, 2);
    check("csum dv count", w_dv_n, 0);
    check("csum held hum", int'(hum_bcd_o), 'h55);
    check("csum held tem", int'(tem_bcd_o), 'h24);

    pulse(40'h63_FF_32_FF_93);
    watch(14);
    check("wrap dv cycle", w_dv_at, 10);
    check("wrap hum", int'(hum_bcd_o), 'h99);
    check("wrap tem", int'(tem_bcd_o), 'h50);

    pulse(40'h64_00_10_00_74);
    watch(8);
    check("hum range cycle", w_re_at, 2);
    check("hum range no csum", w_ce_n, 0);
    check("hum range held hum", int'(hum_bcd_o), 'h99);
    check("hum range held tem", int'(tem_bcd_o), 'h50);

    pulse(40'h10_00_33_00_43);
    watch(8);
    check("tem range cycle", w_re_at, 2);
    check("tem range no dv", w_dv_n, 0);

    pulse(40'h12_05_2A_07_48);
    tick(); tick();
    pulse(40'h05_00_07_00_0C);
    watch(16);
    check("overlap dv count", w_dv_n, 1);
    check("overlap hum", int'(hum_bcd_o), 'h18);
    check("overlap tem", int'(tem_bcd_o), 'h42);

    pulse(40'h05_00_07_00_0C);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort hum", int'(hum_bcd_o), 0);
    check("abort tem", int'(tem_bcd_o), 0);
    check("abort busy", int'(busy_o), 0);
    watch(12);
    check("abort no dv", w_dv_n, 0);
    pulse(40'h12_05_2A_07_48);
    watch(14);
    check("after abort dv cycle", w_dv_at, 10);
    check("after abort hum", int'(hum_bcd_o), 'h18);

    repeat (300) begin
      pulse(mk($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(1, 255)));
      tick();
    end
    repeat (3) tick();
`ifdef DHT_ERRCNT_EN
    check("err_cnt saturate", int'(err_cnt_o), 255);
`else
    check("err_cnt absent", int'(err_cnt_o), 0);
`endif

    repeat (250) begin
      kind = $urandom_range(0, 9);
      hi = $urandom_range(0, HUM_MAX);
      ti = $urandom_range(0, TEM_MAX);
      case (kind)
        0, 1, 2: pulse(mk(hi, $urandom_range(0, 255), ti, $urandom_range(0, 255), 0));
        3:       pulse(mk(hi, $urandom_range(0, 255), ti, $urandom_range(0, 255),
                          $urandom_range(1, 255)));
        4:       pulse(mk($urandom_range(HUM_MAX + 1, 255), $urandom_range(0, 255),
                          ti, $urandom_range(0, 255), 0));
        5:       pulse(mk(hi, $urandom_range(0, 255), $urandom_range(TEM_MAX + 1, 255),
                          $urandom_range(0, 255), 0));
        6:       pulse(mk(($urandom_range(0, 1) != 0) ? HUM_MAX : 0, $urandom_range(0, 255),
                          ($urandom_range(0, 1) != 0) ? TEM_MAX : 0, $urandom_range(0, 255), 0));
        default: pulse({8'($urandom), 32'($urandom)});
      endcase
      repeat ($urandom_range(0, 11)) tick();
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dht_frame_decode.md
DHT_FRAME_DECODE -- requirements
Module: dht_frame_decode

Interface
REQ-001 SHALL have parameter HUM_MAX, default 99: largest accepted humidity integer byte.
REQ-002 SHALL have parameter TEM_MAX, default 50: largest accepted temperature integer byte.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port frame_i  input  40  DHT frame from the humidity receiver: [39:32] hum int, [31:24] hum dec, [23:16] tem int, [15:8] tem dec, [7:0] checksum.
REQ-006 SHALL have port frame_valid_i  input  1  one-cycle pulse; frame_i is valid in that cycle.
REQ-007 SHALL have port hum_bcd_o  output  8  humidity, two BCD digits (tens in [7:4]).
REQ-008 SHALL have port tem_bcd_o  output  8  temperature, two BCD digits (tens in [7:4]).
REQ-009 SHALL have port data_valid_o  output  1  one-cycle pulse when new BCD outputs are loaded.
REQ-010 SHALL have port csum_err_o  output  1  one-cycle pulse on checksum mismatch.
REQ-011 SHALL have port range_err_o  output  1  one-cycle pulse on out-of-range integer byte.
REQ-012 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port err_cnt_o  output  8  error counter (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, CHECK, CONV, DONE.
REQ-015 IDLE: on frame_valid_i=1, capture frame_i into an internal register and go to CHECK.
REQ-016 CHECK (1 cycle): checksum is the low 8 bits of the sum of the four data bytes (mod 256); on mismatch pulse csum_err_o and go to IDLE.
REQ-017 CHECK: if checksum matches but hum int > HUM_MAX or tem int > TEM_MAX, pulse range_err_o and go to IDLE; checksum error takes priority.
REQ-018 CHECK pass: go to CONV, start shift-add-3 binary-to-BCD on both integer bytes in parallel.
REQ-019 CONV SHALL last exactly 8 cycles (one input bit per cycle, MSB first), then go to DONE.
REQ-020 DONE: load hum_bcd_o/tem_bcd_o, pulse data_valid_o, return to IDLE the next cycle.
REQ-021 Latency: data_valid_o SHALL be high in the 10th cycle after the edge at which frame_valid_i is sampled.
REQ-022 frame_valid_i while busy_o=1 SHALL be ignored: no capture, no error pulse.
REQ-023 hum_bcd_o/tem_bcd_o SHALL hold the last good value through checksum or range errors.
REQ-024 Decimal bytes SHALL only enter the checksum and SHALL NOT be range-checked.

Reset
REQ-025 When rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, including hum_bcd_o, tem_bcd_o and err_cnt_o.
REQ-026 Reset during CHECK/CONV/DONE SHALL abort the frame: no data_valid_o or error pulse for it.

Configuration
REQ-027 Macro DHT_ERRCNT_EN defined: err_cnt_o SHALL count csum_err_o plus range_err_o pulses and saturate at 255.
REQ-028 Macro undefined: no counter SHALL be present and err_cnt_o SHALL be constant 0.

Structure
REQ-029 Package dht_pkg SHALL hold the state enum, frame byte-field offsets, and HUM_MAX/TEM_MAX default constants.
REQ-030 Sub-module bin2bcd_seq (8-bit in, 8-bit BCD out, start/done, 8-cycle shift-add-3) SHALL be instantiated twice.

Verification
REQ-031 Frame 0x37_00_18_00_4F -> data_valid_o at cycle 10; hum_bcd_o=0x55, tem_bcd_o=0x24.
REQ-032 Frame 0x37_00_18_00_50 -> csum_err_o pulse at cycle 2; BCD outputs unchanged; no data_valid_o.
REQ-033 Checksum wrap-around: frame 0x63_FF_32_FF_93 -> hum_bcd_o=0x99, tem_bcd_o=0x50. Range: frame 0x64_00_10_00_74 -> range_err_o pulse; outputs held.
REQ-034 Second frame_valid_i 3 cycles after the first -> exactly one data_valid_o, carrying the values of the first frame.
REQ-035 rst asserted for one cycle at cycle 5 of CONV -> no data_valid_o; all outputs 0; the next frame decodes normally.
REQ-036 With DHT_ERRCNT_EN defined, 300 bad-checksum frames -> err_cnt_o=255; without the macro, err_cnt_o=0 throughout.
